iter_square_gen: RTL and testbench

ITER_SQUARE_GEN -- requirements
Module: iter_square_gen

---
 rtl/iter_square_gen_pkg.sv | 15 +
 rtl/iter_square_gen_if.sv | 23 ++
 rtl/iter_square_gen_seqmul_core.sv | 47 ++++
 rtl/iter_square_gen.sv | 109 ++++++++++
 tb/tb_iter_square_gen.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/iter_square_gen_pkg.sv
// rtl/iter_square_gen_pkg.sv - shared mode constants and FSM state encoding
package iter_square_gen_pkg;

    // Second-operand select codes; code 3 is reserved and falls back to square
    localparam logic [1:0] MODE_SQ  = 2'd0;
    localparam logic [1:0] MODE_B   = 2'd1;
    localparam logic [1:0] MODE_INC = 2'd2;

    // Controller state type and encodings
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_MUL  = 2'd1;
    localparam state_t ST_FIN  = 2'd2;

endpackage

// File: rtl/iter_square_gen_if.sv
// rtl/iter_square_gen_if.sv - request/result bundle between host and square generator
interface iter_square_gen_if #(
    parameter int WIN = 16
);
    logic           step_en;
    logic [1:0]     mode;
    logic           load_b;
    logic [7:0]     b_in;
    logic [1:0]     sel;
    logic [WIN-1:0] res;
    logic           busy;
    logic           done;

    modport master (
        output step_en, mode, load_b, b_in, sel,
        input  res, busy, done
    );

    modport slave (
        input  step_en, mode, load_b, b_in, sel,
        output res, busy, done
    );
endinterface

// File: rtl/iter_square_gen_seqmul_core.sv
// rtl/iter_square_gen_seqmul_core.sv - radix-2 shift-add unsigned multiplier datapath
module seqmul_core #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic               run_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic [2*WIDTH-1:0] acc_o,
    output logic               last_o
);
    localparam int IW = $clog2(WIDTH) + 1;

    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [IW-1:0]      iter_q;

    // Capture operands on start, then one conditional add and shift per run cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            iter_q   <= '0;
        end else if (start_i) begin
            acc_q    <= '0;
            mcand_q  <= (2*WIDTH)'(a_i);
            mplier_q <= b_i;
            iter_q   <= '0;
        end else if (run_i) begin
            if (mplier_q[0]) begin
                acc_q <= acc_q + mcand_q;
            end
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            iter_q   <= iter_q + 1'b1;
        end
    end

    assign acc_o  = acc_q;
    // High during the final run cycle so the controller leaves MUL after exactly WIDTH steps
    assign last_o = (iter_q == IW'(WIDTH - 1));

endmodule

// File: rtl/iter_square_gen.sv
// rtl/iter_square_gen.sv - counter-driven iterative multiplier with windowed result
module iter_square_gen
    import iter_square_gen_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int WIN   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    iter_square_gen_if.slave  bus
);
    state_t             state_q, state_d;
    logic [WIDTH-1:0]   cnt_q;
    logic [7:0]         b_q;
    logic [2*WIDTH-1:0] product_q;
    logic               done_q;
    logic [WIDTH-1:0]   opb;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] res_shift;
    logic               core_start;
    logic               core_run;
    logic               core_last;

    // Second operand chosen from the current counter or the stored B value
    always_comb begin
        opb = cnt_q;
        case (bus.mode)
            MODE_B:   opb = WIDTH'(b_q);
            MODE_INC: opb = cnt_q + WIDTH'(1);
            default:  opb = cnt_q;
        endcase
    end

    // Controller: accept a step only in IDLE, run WIDTH multiply cycles, then one finish cycle
    always_comb begin
        state_d    = state_q;
        core_start = 1'b0;
        core_run   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.step_en) begin
                    core_start = 1'b1;
                    state_d    = ST_MUL;
                end
            end
            ST_MUL: begin
                core_run = 1'b1;
                if (core_last) begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // B register loads in any state; the core keeps its own captured copy
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            b_q <= '0;
        end else if (bus.load_b) begin
            b_q <= bus.b_in;
        end
    end

    // Finish cycle publishes the product, pulses done and advances the counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            product_q <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= (state_q == ST_FIN);
            if (state_q == ST_FIN) begin
                product_q <= acc;
                cnt_q     <= cnt_q + WIDTH'(1);
            end
        end
    end

    seqmul_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (core_start),
        .run_i   (core_run),
        .a_i     (cnt_q),
        .b_i     (opb),
        .acc_o   (acc),
        .last_o  (core_last)
    );

    // Windows past the top of the product shift out to zero
    assign res_shift = product_q >> (WIN * int'(bus.sel));
    assign bus.res   = res_shift[WIN-1:0];
    assign bus.busy  = (state_q != ST_IDLE);
    assign bus.done  = done_q;

endmodule

// File: tb/tb_iter_square_gen.sv
// tb/tb_iter_square_gen.sv - scoreboard bench for iter_square_gen at WIDTH 32 and 8
module tb_iter_square_gen;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic rst32_n;
    logic rst8_n;

    iter_square_gen_if #(.WIN(16)) bus32 ();
    iter_square_gen_if #(.WIN(8))  bus8 ();

    iter_square_gen #(.WIDTH(32), .WIN(16)) dut32 (.clk(clk), .rst_n(rst32_n), .bus(bus32));
    iter_square_gen #(.WIDTH(8),  .WIN(8))  dut8  (.clk(clk), .rst_n(rst8_n),  .bus(bus8));

    typedef struct {
        logic [63:0] prod;
        int          issue;
    } exp_t;

    exp_t q32[$];
    exp_t q8[$];
    exp_t e32;
    exp_t e8;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int dcnt32   = 0;
    int dcnt8    = 0;

    longint unsigned cnt_m[2];
    longint unsigned b_m[2];
    longint unsigned last_prod[2];

    always @(posedge clk) cyc++;

    function automatic logic [63:0] win_of(logic [63:0] p, int s, int win, int w);
        int sh;
        sh = win * s;
        if (sh >= 2 * w) return 64'd0;
        return (p >> sh) & ((64'd1 << win) - 64'd1);
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitors: every done pulse pops the oldest expectation and checks result and latency
    always @(negedge clk) begin
        if (bus32.done === 1'b1) begin
            dcnt32++;
            if (q32.size() == 0) begin
                chk("unexpected_done32", 64'd1, 64'd0);
            end else begin
                e32 = q32.pop_front();
                chk("res32", 64'(bus32.res), win_of(e32.prod, int'(bus32.sel), 16, 32));
                chk("latency32", 64'(cyc - e32.issue), 64'd33);
            end
        end
    end

    always @(negedge clk) begin
        if (bus8.done === 1'b1) begin
            dcnt8++;
            if (q8.size() == 0) begin
                chk("unexpected_done8", 64'd1, 64'd0);
            end else begin
                e8 = q8.pop_front();
                chk("res8", 64'(bus8.res), win_of(e8.prod, int'(bus8.sel), 8, 8));
                chk("latency8", 64'(cyc - e8.issue), 64'd9);
            end
        end
    end

    task automatic drive(input int d, input bit st, input logic [1:0] m, input logic [1:0] s,
                         input bit ld, input logic [7:0] bv);
        if (d == 0) begin
            bus32.step_en = st; bus32.mode = m; bus32.sel = s; bus32.load_b = ld; bus32.b_in = bv;
        end else begin
            bus8.step_en = st; bus8.mode = m; bus8.sel = s; bus8.load_b = ld; bus8.b_in = bv;
        end
    endtask

    function automatic logic get_busy(input int d);
        return (d == 0) ? bus32.busy : bus8.busy;
    endfunction

    function automatic logic [63:0] get_res(input int d);
        return (d == 0) ? 64'(bus32.res) : 64'(bus8.res);
    endfunction

    task automatic set_sel(input int d, input logic [1:0] s);
        if (d == 0) bus32.sel = s; else bus8.sel = s;
    endtask

    // One request; poke pulses step_en and reloads B while the multiply is in flight
    task automatic issue(input int d, input logic [1:0] m, input logic [1:0] s,
                         input bit ld, input logic [7:0] bv, input bit poke);
        longint unsigned mask, a, b;
        int w, busy_n;
        exp_t e;
        logic [7:0] bv2;
        w    = (d == 0) ? 32 : 8;
        mask = (d == 0) ? 64'hFFFF_FFFF : 64'hFF;
        a    = cnt_m[d];
        case (m)
            2'd1:    b = b_m[d];
            2'd2:    b = (cnt_m[d] + 1) & mask;
            default: b = a;
        endcase
        e.prod       = a * b;
        e.issue      = cyc + 1;
        last_prod[d] = e.prod;
        if (d == 0) q32.push_back(e); else q8.push_back(e);
        cnt_m[d] = (a + 1) & mask;
        if (ld) b_m[d] = {56'd0, bv};
        drive(d, 1'b1, m, s, ld, bv);
        @(posedge clk); #1;
        drive(d, 1'b0, m, s, 1'b0, bv);
        busy_n = 0;
        bv2    = 8'd0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (get_busy(d)) busy_n++; else break;
            if (poke && k == 5) begin
                bv2    = 8'($urandom);
                b_m[d] = {56'd0, bv2};
                drive(d, 1'b1, m, s, 1'b1, bv2);
            end
            if (poke && k == 7) drive(d, 1'b0, m, s, 1'b0, bv2);
        end
        chk((d == 0) ? "busy_cycles32" : "busy_cycles8", 64'(busy_n), 64'(w + 1));
        @(posedge clk); #1;
    endtask

    task automatic load_only(input int d, input logic [7:0] bv);
        drive(d, 1'b0, 2'd0, 2'd0, 1'b1, bv);
        b_m[d] = {56'd0, bv};
        @(posedge clk); #1;
        drive(d, 1'b0, 2'd0, 2'd0, 1'b0, bv);
    endtask

    // Product register must hold and every window must match the last model product
    task automatic sweep(input int d);
        int w, win;
        w   = (d == 0) ? 32 : 8;
        win = (d == 0) ? 16 : 8;
        for (int s = 0; s < 4; s++) begin
            set_sel(d, 2'(s));
            #1;
            chk((d == 0) ? "sweep32" : "sweep8", get_res(d), win_of(last_prod[d], s, win, w));
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset(input int d);
        if (d == 0) rst32_n = 1'b0; else rst8_n = 1'b0;
        drive(d, 1'b0, 2'd0, 2'd0, 1'b0, 8'd0);
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 4; s++) begin
            set_sel(d, 2'(s));
            #1;
            chk("reset_res", get_res(d), 64'd0);
        end
        chk("reset_busy", 64'(get_busy(d)), 64'd0);
        chk("reset_done", (d == 0) ? 64'(bus32.done) : 64'(bus8.done), 64'd0);
        @(posedge clk); #1;
        if (d == 0) begin rst32_n = 1'b1; q32.delete(); end
        else        begin rst8_n  = 1'b1; q8.delete();  end
        cnt_m[d] = 0; b_m[d] = 0; last_prod[d] = 0;
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, c;
        exp_t e;
        rst32_n = 1'b0;
        rst8_n  = 1'b0;
        drive(0, 1'b0, 2'd0, 2'd0, 1'b0, 8'd0);
        drive(1, 1'b0, 2'd0, 2'd0, 1'b0, 8'd0);
        do_reset(0);
        do_reset(1);

        // Squares 0, 1, 4 from back-to-back steps
        issue(0, 2'd0, 2'd0, 1'b0, 8'd0, 1'b0);
        sweep(0);
        issue(0, 2'd0, 2'd1, 1'b0, 8'd0, 1'b0);
        issue(0, 2'd0, 2'd0, 1'b0, 8'd0, 1'b0);
        sweep(0);

        // B register operand: 3 * 0xFF
        load_only(0, 8'hFF);
        issue(0, 2'd1, 2'd0, 1'b0, 8'd0, 1'b0);
        bus32.sel = 2'd0;
        #1;
        chk("b_mode_765", 64'(bus32.res), 64'h02FD);
        sweep(0);

        // Load in the same cycle as the step uses the previous B
        issue(0, 2'd1, 2'd0, 1'b1, 8'h10, 1'b0);
        issue(0, 2'd1, 2'd0, 1'b0, 8'd0, 1'b0);
        sweep(0);

        // Requests and B loads during busy must not disturb the operation in flight
        issue(0, 2'd1, 2'd0, 1'b0, 8'd0, 1'b1);
        issue(0, 2'd1, 2'd0, 1'b0, 8'd0, 1'b0);

        // Random modes, windows and loads
        for (int i = 0; i < 16; i++) begin
            issue(0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 8'($urandom), (i % 4) == 0);
            if (i % 5 == 0) sweep(0);
        end

        // step_en held high for 100 cycles: accepted at offsets 0, 34 and 68
        c  = cyc + 1;
        d0 = dcnt32;
        for (int j = 0; j < 3; j++) begin
            e.prod  = cnt_m[0] * cnt_m[0];
            e.issue = c + 34 * j;
            q32.push_back(e);
            last_prod[0] = e.prod;
            cnt_m[0]     = (cnt_m[0] + 1) & 64'hFFFF_FFFF;
        end
        drive(0, 1'b1, 2'd0, 2'd0, 1'b0, 8'd0);
        repeat (100) @(posedge clk);
        #1;
        drive(0, 1'b0, 2'd0, 2'd0, 1'b0, 8'd0);
        chk("held_done_count", 64'(dcnt32 - d0), 64'd2);
        for (int k = 0; k < 60 && q32.size() != 0; k++) @(posedge clk);
        #1;
        chk("held_drain", 64'(q32.size()), 64'd0);
        sweep(0);

        // Reset for one cycle in the middle of a multiply
        drive(0, 1'b1, 2'd0, 2'd0, 1'b0, 8'd0);
        @(posedge clk); #1;
        drive(0, 1'b0, 2'd0, 2'd0, 1'b0, 8'd0);
        repeat (10) @(posedge clk);
        #1;
        rst32_n = 1'b0;
        @(posedge clk); #1;
        rst32_n = 1'b1;
        cnt_m[0] = 0; b_m[0] = 0; last_prod[0] = 0;
        d0 = dcnt32;
        repeat (40) @(posedge clk);
        #1;
        chk("abort_no_done", 64'(dcnt32 - d0), 64'd0);
        issue(0, 2'd0, 2'd0, 1'b0, 8'd0, 1'b0);
        sweep(0);
        issue(0, 2'd0, 2'd0, 1'b0, 8'd0, 1'b0);
        sweep(0);

        // WIDTH=8: walk the counter to 255, square it, then wrap
        for (int i = 0; i < 255; i++)
            issue(1, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 8'($urandom), 1'b0);
        issue(1, 2'd0, 2'd0, 1'b0, 8'd0, 1'b0);
        bus8.sel = 2'd0; #1; chk("sq255_sel0", 64'(bus8.res), 64'h01);
        bus8.sel = 2'd1; #1; chk("sq255_sel1", 64'(bus8.res), 64'hFE);
        bus8.sel = 2'd2; #1; chk("sq255_sel2", 64'(bus8.res), 64'h00);
        @(posedge clk); #1;
        issue(1, 2'd2, 2'd0, 1'b0, 8'd0, 1'b0);
        bus8.sel = 2'd0; #1; chk("wrap_cnt0_inc", 64'(bus8.res), 64'h00);
        @(posedge clk); #1;
        for (int i = 0; i < 254; i++)
            issue(1, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 8'($urandom), 1'b0);
        issue(1, 2'd2, 2'd0, 1'b0, 8'd0, 1'b0);
        sweep(1);
        issue(1, 2'd0, 2'd0, 1'b0, 8'd0, 1'b0);
        sweep(1);

        chk("q32_empty", 64'(q32.size()), 64'd0);
        chk("q8_empty", 64'(q8.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
